// File: rtl/n64_pkg.sv
// Shared Joybus definitions for the fake N64 controller: FSM states, bit-cell
// geometry, command codes and response lengths.
package n64_pkg;

   typedef enum logic [1:0] {IDLE, GAP, BIT, STOP} state_e;

   localparam int SLOTS_PER_BIT = 4;
   localparam int STOP_SLOTS    = 2;

   localparam logic [7:0] CMD_INFO   = 8'h00;
   localparam logic [7:0] CMD_STATUS = 8'h01;
   localparam logic [7:0] CMD_READ   = 8'h02;
   localparam logic [7:0] CMD_WRITE  = 8'h03;
   localparam logic [7:0] CMD_RESET  = 8'hFF;

   localparam int RESP_LEN_INFO   = 3;
   localparam int RESP_LEN_STATUS = 4;

endpackage

// File: rtl/n64_response_tx_if.sv
// Load/status bundle between the command receiver (master) and the response
// transmitter (slave), plus the open-drain pad enable.
interface n64_response_tx_if #(
   parameter int MAX_BYTES = 4
);
   logic                   start;
   logic [2:0]             len;
   logic [8*MAX_BYTES-1:0] payload;
   logic                   busy;
   logic                   done;
   logic                   line_low;

   modport master (output start, len, payload, input busy, done, line_low);
   modport slave  (input start, len, payload, output busy, done, line_low);
endinterface

// File: rtl/n64_us_tick.sv
// 1 us slot prescaler: strobes tick on the last clk of every slot; clr holds
// the count at zero so the first slot after a load is full length.
module n64_us_tick #(
   parameter int TICKS_PER_US = 50
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clr,
   output logic tick
);
   localparam int CW = $clog2(TICKS_PER_US);

   logic [CW-1:0] cnt_q, cnt_d;

   assign tick = (cnt_q == CW'(TICKS_PER_US - 1));

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clr || tick) cnt_d = '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end

endmodule

// File: rtl/n64_response_tx.sv
// Joybus response serialiser: turnaround gap, 4-slot bit cells MSB first,
// then a 2-slot low stop bit. Drives only the open-drain pull-low enable.
module n64_response_tx
   import n64_pkg::*;
#(
   parameter int TICKS_PER_US = 50,
   parameter int MAX_BYTES    = 4,
   parameter int GAP_US       = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   n64_response_tx_if.slave  bus
);
   localparam int PW       = 8 * MAX_BYTES;
   localparam int BL_W     = $clog2(8 * MAX_BYTES + 1);
   localparam int SLOT_MAX = (GAP_US > SLOTS_PER_BIT) ? GAP_US : SLOTS_PER_BIT;
   localparam int SLOT_W   = $clog2(SLOT_MAX);

   state_e            state_q, state_d;
   logic [SLOT_W-1:0] slot_q, slot_d;
   logic [BL_W-1:0]   bits_left_q, bits_left_d;
   logic [PW-1:0]     shreg_q, shreg_d;
   logic              line_low_q, line_low_d;
   logic              done_q, done_d;
   logic              tick;
   logic              len_ok;

   n64_us_tick #(.TICKS_PER_US(TICKS_PER_US)) u_tick (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (state_q == IDLE),
      .tick    (tick)
   );

   assign len_ok = (bus.len != 3'd0) && (int'(bus.len) <= MAX_BYTES);

   always_comb begin
      state_d     = state_q;
      slot_d      = slot_q;
      bits_left_d = bits_left_q;
      shreg_d     = shreg_q;
      done_d      = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start && len_ok) begin
               shreg_d     = bus.payload;
               bits_left_d = BL_W'({bus.len, 3'b000});
               slot_d      = '0;
               state_d     = (GAP_US == 0) ? BIT : GAP;
            end
         end
         GAP: begin
            if (tick) begin
               if (slot_q == SLOT_W'(GAP_US - 1)) begin
                  slot_d  = '0;
                  state_d = BIT;
               end else begin
                  slot_d = slot_q + 1'b1;
               end
            end
         end
         BIT: begin
            if (tick) begin
               if (slot_q == SLOT_W'(SLOTS_PER_BIT - 1)) begin
                  slot_d      = '0;
                  shreg_d     = shreg_q << 1;
                  bits_left_d = bits_left_q - 1'b1;
                  if (bits_left_q == BL_W'(1)) state_d = STOP;
               end else begin
                  slot_d = slot_q + 1'b1;
               end
            end
         end
         STOP: begin
            if (tick) begin
               if (slot_q == SLOT_W'(STOP_SLOTS - 1)) begin
                  slot_d  = '0;
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  slot_d = slot_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Pad level is derived from the next state so it lands on the same edge
      // as the state change and leaves the flop with no input-to-pad path.
      line_low_d = 1'b0;
      case (state_d)
         BIT: begin
            if (slot_d == '0)                            line_low_d = 1'b1;
            else if (slot_d != SLOT_W'(SLOTS_PER_BIT-1)) line_low_d = ~shreg_d[PW-1];
         end
         STOP:    line_low_d = 1'b1;
         default: line_low_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         slot_q      <= '0;
         bits_left_q <= '0;
         shreg_q     <= '0;
         line_low_q  <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         slot_q      <= slot_d;
         bits_left_q <= bits_left_d;
         shreg_q     <= shreg_d;
         line_low_q  <= line_low_d;
         done_q      <= done_d;
      end
   end

   assign bus.busy     = (state_q != IDLE);
   assign bus.done     = done_q;
   assign bus.line_low = line_low_q;

endmodule

// File: tb/tb_n64_response_tx.sv
// Bench for n64_response_tx: two instances (no gap / 2 us gap) share stimulus
// and are checked every cycle against a waveform model of the Joybus frame.
module tb_n64_response_tx;
   import n64_pkg::*;

   localparam int T  = 4;
   localparam int MB = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  len = 3'd0;
   logic [31:0] payload = 32'd0;

   always #5 clk = ~clk;

   n64_response_tx_if #(.MAX_BYTES(MB)) bus0 ();
   n64_response_tx_if #(.MAX_BYTES(MB)) bus2 ();

   assign bus0.start = start;
   assign bus0.len = len;
   assign bus0.payload = payload;
   assign bus2.start = start;
   assign bus2.len = len;
   assign bus2.payload = payload;

   n64_response_tx #(.TICKS_PER_US(T), .MAX_BYTES(MB), .GAP_US(0)) dut0 (
      .clk(clk), .reset_n(rst_n), .bus(bus0));
   n64_response_tx #(.TICKS_PER_US(T), .MAX_BYTES(MB), .GAP_US(2)) dut2 (
      .clk(clk), .reset_n(rst_n), .bus(bus2));

   int checks = 0;
   int errors = 0;

   // ---------------- behavioural model ----------------
   function automatic int gap_of(int d);
      return (d == 0) ? 0 : 2;
   endfunction

   function automatic int frame_len(int gap, int l);
      return (gap + 32 * l + 2) * T;
   endfunction

   // Expected {line_low, busy, done} k cycles after the accepting edge.
   function automatic logic [2:0] exp_at(int gap, int l, logic [31:0] pl, int k);
      int gt, bt, kb, b, s;
      logic bv;
      gt = gap * T;
      bt = 32 * l * T;
      if (k < gt) return 3'b010;
      kb = k - gt;
      if (kb < bt) begin
         b  = kb / (4 * T);
         s  = (kb % (4 * T)) / T;
         bv = pl[31 - b];
         return {(s == 0) || (s < 3 && !bv), 2'b10};
      end
      if (kb < bt + 2 * T) return 3'b110;
      if (kb == bt + 2 * T) return 3'b001;
      return 3'b000;
   endfunction

   bit          m_act [2];
   int          m_k   [2];
   int          m_len [2];
   logic [31:0] m_pl  [2];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int d = 0; d < 2; d++) begin
            m_act[d] = 1'b0;
            m_k[d]   = 0;
            m_len[d] = 0;
            m_pl[d]  = '0;
         end
      end else begin
         for (int d = 0; d < 2; d++) begin
            bit busy_prev;
            busy_prev = m_act[d] && (m_k[d] < frame_len(gap_of(d), m_len[d]));
            if (m_act[d]) begin
               m_k[d] = m_k[d] + 1;
               if (m_k[d] > frame_len(gap_of(d), m_len[d])) m_act[d] = 1'b0;
            end
            if (!busy_prev && start && len >= 3'd1 && int'(len) <= MB) begin
               m_act[d] = 1'b1;
               m_k[d]   = 0;
               m_len[d] = int'(len);
               m_pl[d]  = payload;
            end
         end
      end
   end

   // ---------------- single compare process ----------------
   bit    pin_v = 1'b0;
   string pin_nm = "";
   int    pin_act = 0;
   int    pin_exp = 0;

   always @(negedge clk) begin
      logic [2:0] a0, a2, e0, e2;
      if (pin_v) begin
         checks++;
         if (pin_act != pin_exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", pin_nm, pin_act, pin_exp);
         end
      end
      if (rst_n) begin
         a0 = {bus0.line_low, bus0.busy, bus0.done};
         a2 = {bus2.line_low, bus2.busy, bus2.done};
         e0 = m_act[0] ? exp_at(0, m_len[0], m_pl[0], m_k[0]) : 3'b000;
         e2 = m_act[1] ? exp_at(2, m_len[1], m_pl[1], m_k[1]) : 3'b000;
         checks += 2;
         if (a0 !== e0) begin
            errors++;
            $display("FAIL wave_gap0 t=%0t: {low,busy,done} got %b, expected %b", $time, a0, e0);
         end
         if (a2 !== e2) begin
            errors++;
            $display("FAIL wave_gap2 t=%0t: {low,busy,done} got %b, expected %b", $time, a2, e2);
         end
      end
   end

   task automatic pin(input string nm, input int act, input int exp);
      pin_nm  = nm;
      pin_act = act;
      pin_exp = exp;
      pin_v   = 1'b1;
      @(negedge clk);
      #1 pin_v = 1'b0;
   endtask

   // Pulse start for one cycle, then time the done pulse of each instance.
   // k=0 is the first cycle after the accepting edge; -1 means it never came.
   task automatic send(input logic [2:0] l, input logic [31:0] p,
                       output int k0, output int k2, output int ll0, output int ll2);
      @(negedge clk);
      start = 1'b1;
      len = l;
      payload = p;
      @(negedge clk);
      start = 1'b0;
      ll0 = int'(bus0.line_low);
      ll2 = int'(bus2.line_low);
      k0 = -1;
      k2 = -1;
      for (int k = 1; k < 2000; k++) begin
         @(negedge clk);
         if (bus0.done && k0 < 0) k0 = k;
         if (bus2.done && k2 < 0) k2 = k;
         if (k0 >= 0 && k2 >= 0) break;
      end
   endtask

   initial begin
      int k0, k2, ll0, ll2, n0, n2, bad, d0a, d0b, d2a, d2b;

      // reset state
      #23;
      pin("reset_outputs", int'({bus0.line_low, bus0.busy, bus0.done,
                                 bus2.line_low, bus2.busy, bus2.done}), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // info response 05 00 02
      send(3'(RESP_LEN_INFO), 32'h0500_0200, k0, k2, ll0, ll2);
      pin("info_first_low_gap0", ll0, 1);
      pin("info_first_low_gap2", ll2, 0);
      pin("info_done_gap0", k0, 392);
      pin("info_done_gap2", k2, 400);

      // single byte 0x80
      send(3'd1, 32'h8000_0000, k0, k2, ll0, ll2);
      pin("len1_first_low_gap0", ll0, 1);
      pin("len1_done_gap0", k0, 136);
      pin("len1_done_gap2", k2, 144);

      // start pulsed mid-frame with different payload
      @(negedge clk);
      start = 1'b1; len = 3'd1; payload = 32'h8000_0000;
      n0 = 0; n2 = 0;
      for (int k = 0; k < 600; k++) begin
         @(negedge clk);
         start = (k == 50);
         if (k == 50) begin len = 3'd2; payload = 32'h1234_5678; end
         if (bus0.done) n0++;
         if (bus2.done) n2++;
      end
      pin("midframe_dones_gap0", n0, 1);
      pin("midframe_dones_gap2", n2, 1);

      // illegal lengths
      bad = 0;
      start = 1'b1; len = 3'd0; payload = 32'hFFFF_FFFF;
      for (int k = 0; k < 1000; k++) begin
         @(negedge clk);
         if (k == 500) len = 3'd5;
         if (bus0.busy || bus0.done || bus0.line_low ||
             bus2.busy || bus2.done || bus2.line_low) bad++;
      end
      start = 1'b0;
      pin("bad_len_activity", bad, 0);

      // reset during bit 10 of a status response
      @(negedge clk);
      start = 1'b1; len = 3'(RESP_LEN_STATUS); payload = $urandom;
      @(negedge clk);
      start = 1'b0;
      repeat (2 * T + 10 * 4 * T + 6) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      pin("async_reset_release", int'({bus0.line_low, bus0.busy,
                                       bus2.line_low, bus2.busy}), 0);
      @(negedge clk);
      rst_n = 1'b1;
      send(3'(RESP_LEN_STATUS), $urandom, k0, k2, ll0, ll2);
      pin("post_reset_done_gap0", k0, 520);
      pin("post_reset_done_gap2", k2, 528);

      // start held high: frames back to back
      @(negedge clk);
      start = 1'b1; len = 3'd1; payload = $urandom;
      d0a = -1; d0b = -1; d2a = -1; d2b = -1;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         if (bus0.done) begin if (d0a < 0) d0a = k; else if (d0b < 0) d0b = k; end
         if (bus2.done) begin if (d2a < 0) d2a = k; else if (d2b < 0) d2b = k; end
      end
      start = 1'b0;
      pin("b2b_period_gap0", d0b - d0a, 137);
      pin("b2b_period_gap2", d2b - d2a, 145);
      repeat (200) @(negedge clk);

      // randomized traffic, model-checked every cycle
      for (int it = 0; it < 25; it++) begin
         start = 1'b1;
         len = 3'($urandom_range(0, 5));
         payload = $urandom;
         @(negedge clk);
         start = 1'b0;
         repeat ($urandom_range(50, 600)) begin
            @(negedge clk);
            if ($urandom_range(0, 40) == 0) begin
               start = 1'b1;
               len = 3'($urandom_range(0, 5));
               payload = $urandom;
            end else begin
               start = 1'b0;
            end
         end
      end
      start = 1'b0;
      repeat (600) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
